// File: rtl/mc_control.sv
// mc_control: multicycle control FSM sequencing fetch/decode/execute/memory/writeback,
// with a memory-handshake timeout and a retired-instruction counter.
module mc_control #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  op_i,
    input  logic [5:0]  funct_i,
    input  logic        mem_ack_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        iord_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic        br_en_o,
    output logic        reg_we_o,
    output logic        regdst_o,
    output logic        memtoreg_o,
    output logic        alusrc_a_o,
    output logic [1:0]  alusrc_b_o,
    output logic [2:0]  alu_op_o,
    output logic [1:0]  ext_sel_o,
    output logic [1:0]  pc_src_o,
    output logic [2:0]  state_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [31:0] instr_cnt_o
);
    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5} state_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100, OP_ORI = 6'b001101,
                           OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010,
                           OP_HALT = 6'b111111;
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        err_q, err_d, run_q;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  wait_q, wait_d;
    logic        legal, unused_funct;
    logic [1:0]  ext;

    assign unused_funct = ^funct_i;
    assign legal = op_i inside {OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT};
    assign ext = (op_i == OP_ANDI || op_i == OP_ORI) ? 2'b11 : op_i == OP_BEQ ? 2'b01 : 2'b00;
    assign state_o = state_q;
    assign busy_o = state_q != HALT;
    assign err_o = err_q;
    assign instr_cnt_o = cnt_q;

    // run_q keeps every strobe low until the first clock edge after reset releases
    always_comb begin
        state_d = state_q;
        err_d = err_q;
        cnt_d = cnt_q;
        mem_req_o = 1'b0;
        mem_we_o = 1'b0;
        iord_o = 1'b0;
        ir_we_o = 1'b0;
        pc_we_o = 1'b0;
        br_en_o = 1'b0;
        reg_we_o = 1'b0;
        regdst_o = 1'b0;
        memtoreg_o = 1'b0;
        alusrc_a_o = 1'b0;
        alusrc_b_o = 2'b00;
        alu_op_o = 3'b000;
        ext_sel_o = 2'b00;
        pc_src_o = 2'b00;
        if (run_q) begin
            case (state_q)
                FETCH: begin
                    mem_req_o = 1'b1;
                    alusrc_b_o = 2'b01;
                    if (mem_ack_i) begin
                        ir_we_o = 1'b1;
                        pc_we_o = 1'b1;
                        state_d = DECODE;
                    end else if (wait_q == TO_LAST) begin
                        state_d = HALT;
                        err_d = 1'b1;
                    end
                end
                DECODE: begin
                    ext_sel_o = ext;
                    if (op_i == OP_J) begin
                        pc_we_o = 1'b1;
                        pc_src_o = 2'b10;
                        cnt_d = cnt_q + 32'd1;
                        state_d = FETCH;
                    end else if (!legal || op_i == OP_HALT) begin
                        err_d = !legal;
                        state_d = HALT;
                    end else begin
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    ext_sel_o = ext;
                    alusrc_a_o = 1'b1;
                    if (op_i == OP_BEQ) begin
                        alu_op_o = 3'b001;
                        br_en_o = 1'b1;
                        pc_src_o = 2'b01;
                        cnt_d = cnt_q + 32'd1;
                        state_d = FETCH;
                    end else begin
                        alusrc_b_o = op_i == OP_R ? 2'b00 : 2'b10;
                        alu_op_o = op_i == OP_R ? 3'b100 : op_i == OP_ANDI ? 3'b010 : op_i == OP_ORI ? 3'b011 : 3'b000;
                        state_d = (op_i == OP_LW || op_i == OP_SW) ? MEM : WB;
                    end
                end
                MEM: begin
                    ext_sel_o = ext;
                    mem_req_o = 1'b1;
                    iord_o = 1'b1;
                    mem_we_o = op_i == OP_SW;
                    if (mem_ack_i) begin
                        cnt_d = op_i == OP_SW ? cnt_q + 32'd1 : cnt_q;
                        state_d = op_i == OP_SW ? FETCH : WB;
                    end else if (wait_q == TO_LAST) begin
                        state_d = HALT;
                        err_d = 1'b1;
                    end
                end
                WB: begin
                    ext_sel_o = ext;
                    reg_we_o = 1'b1;
                    regdst_o = op_i == OP_R;
                    memtoreg_o = op_i == OP_LW;
                    cnt_d = cnt_q + 32'd1;
                    state_d = FETCH;
                end
                HALT: ;
                default: begin
                    state_d = HALT;
                    err_d = 1'b1;
                end
            endcase
        end
        wait_d = (mem_req_o && !mem_ack_i && state_d == state_q) ? wait_q + 8'd1 : 8'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            err_q <= 1'b0;
            cnt_q <= 32'd0;
            wait_q <= 8'd0;
            run_q <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
            wait_q <= wait_d;
            run_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: bench for mc_control -- directed corner sequences, a vector table,
// and random instructions checked against a latency/effect model.
module tb_mc_control;
    localparam int TO = 4;
    localparam logic [5:0] R_OP = 6'b000000, ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101,
                           LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, J_OP = 6'b000010,
                           HALT_OP = 6'b111111;

    logic clk = 1'b0, rst_n = 1'b0, mem_ack_i = 1'b0;
    logic [5:0] op_i = 6'd0, funct_i = 6'd0;
    logic mem_req_o, mem_we_o, iord_o, ir_we_o, pc_we_o, br_en_o, reg_we_o, regdst_o, memtoreg_o, alusrc_a_o;
    logic [1:0] alusrc_b_o, ext_sel_o, pc_src_o;
    logic [2:0] alu_op_o, state_o;
    logic busy_o, err_o;
    logic [31:0] instr_cnt_o;

    always #5 clk = ~clk;

    mc_control #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .op_i(op_i), .funct_i(funct_i), .mem_ack_i(mem_ack_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .iord_o(iord_o), .ir_we_o(ir_we_o), .pc_we_o(pc_we_o),
        .br_en_o(br_en_o), .reg_we_o(reg_we_o), .regdst_o(regdst_o), .memtoreg_o(memtoreg_o),
        .alusrc_a_o(alusrc_a_o), .alusrc_b_o(alusrc_b_o), .alu_op_o(alu_op_o), .ext_sel_o(ext_sel_o),
        .pc_src_o(pc_src_o), .state_o(state_o), .busy_o(busy_o), .err_o(err_o), .instr_cnt_o(instr_cnt_o)
    );

    typedef struct packed {
        logic [2:0] st;
        logic req, we, iord, irwe, pcwe, br, rwe, rdst, m2r, asa;
        logic [1:0] asb;
        logic [2:0] aop;
        logic [1:0] ext, psrc;
    } snap_t;
    typedef struct { int cyc; int rwe; int mwe; int inc; logic [2:0] fin; logic err; } exp_t;
    typedef struct { logic [5:0] op; int fd; int md; exp_t e; } vec_t;

    snap_t tr [64];
    int checks = 0, errors = 0, exp_cnt = 0;
    int n_cyc, n_ir, n_pc, n_rwe, n_mwe;
    vec_t vt [11];
    logic [5:0] ops [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(state_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_cnt", instr_cnt_o, 0);
        chk("rst_req", 32'(mem_req_o), 0);
        #2 rst_n = 1'b1;
    endtask

    // Fetch waits fd cycles for ack, a data access waits md; ack is noise while mem_req is low
    task automatic run_instr(input logic [5:0] op, input int fd, input int md);
        logic [2:0] ps;
        int w;
        bit left, done;
        ps = 3'd7; w = 0; left = 0; done = 0;
        n_cyc = 0; n_ir = 0; n_pc = 0; n_rwe = 0; n_mwe = 0;
        op_i = op;
        funct_i = 6'($urandom);
        @(negedge clk);
        for (int c = 0; c < 40 && !done; c++) begin
            if (state_o != ps) begin w = 0; ps = state_o; end
            mem_ack_i = mem_req_o ? (w == (state_o == 3'd3 ? md : fd)) : 1'($urandom);
            #1;
            tr[c] = '{state_o, mem_req_o, mem_we_o, iord_o, ir_we_o, pc_we_o, br_en_o, reg_we_o, regdst_o,
                      memtoreg_o, alusrc_a_o, alusrc_b_o, alu_op_o, ext_sel_o, pc_src_o};
            n_ir += int'(ir_we_o);
            n_pc += int'(pc_we_o);
            n_rwe += int'(reg_we_o);
            n_mwe += int'(mem_we_o);
            if (mem_req_o && !mem_ack_i) w++;
            @(posedge clk);
            #1;
            n_cyc++;
            done = state_o == 3'd5 || (left && state_o == 3'd0);
            if (state_o != 3'd0) left = 1;
            if (!done) @(negedge clk);
        end
        chk("instr_done", 32'(done), 1);
    endtask

    function automatic exp_t model(input logic [5:0] op, input int fd, input int md);
        exp_t e;
        e = '{cyc: 0, rwe: 0, mwe: 0, inc: 0, fin: 3'd0, err: 1'b0};
        if (fd >= TO) begin
            e.cyc = TO; e.fin = 3'd5; e.err = 1'b1;
            return e;
        end
        case (op)
            J_OP, BEQ: begin e.cyc = op == J_OP ? 2 : 3; e.inc = 1; end
            R_OP, ADDI, ANDI, ORI: begin e.cyc = 4; e.rwe = 1; e.inc = 1; end
            SW, LW: begin
                if (md >= TO) begin
                    e.cyc = 3 + TO; e.mwe = op == SW ? TO : 0; e.fin = 3'd5; e.err = 1'b1;
                end else begin
                    e.cyc = op == SW ? 4 + md : 5 + md;
                    e.mwe = op == SW ? md + 1 : 0;
                    e.rwe = op == LW ? 1 : 0;
                    e.inc = 1;
                end
            end
            HALT_OP: begin e.cyc = 2; e.fin = 3'd5; end
            default: begin e.cyc = 2; e.fin = 3'd5; e.err = 1'b1; end
        endcase
        e.cyc += fd;
        return e;
    endfunction

    task automatic check_run(input string tag, input exp_t e);
        exp_cnt += e.inc;
        chk({tag, "_cycles"}, n_cyc, e.cyc);
        chk({tag, "_reg_we"}, n_rwe, e.rwe);
        chk({tag, "_mem_we"}, n_mwe, e.mwe);
        chk({tag, "_state"}, 32'(state_o), 32'(e.fin));
        chk({tag, "_err"}, 32'(err_o), 32'(e.err));
        chk({tag, "_cnt"}, instr_cnt_o, exp_cnt);
        if (e.fin == 3'd5) begin
            chk({tag, "_busy"}, 32'(busy_o), 0);
            do_reset();
            exp_cnt = 0;
        end
    endtask

    initial begin
        ops = '{R_OP, ADDI, ANDI, ORI, LW, SW, BEQ, J_OP, HALT_OP};
        vt[0]  = '{R_OP,       0, 0, '{4, 1, 0, 1, 3'd0, 1'b0}};
        vt[1]  = '{ADDI,       2, 0, '{6, 1, 0, 1, 3'd0, 1'b0}};
        vt[2]  = '{ANDI,       1, 0, '{5, 1, 0, 1, 3'd0, 1'b0}};
        vt[3]  = '{J_OP,       0, 0, '{2, 0, 0, 1, 3'd0, 1'b0}};
        vt[4]  = '{SW,         0, 2, '{6, 0, 3, 1, 3'd0, 1'b0}};
        vt[5]  = '{LW,         1, 0, '{6, 1, 0, 1, 3'd0, 1'b0}};
        vt[6]  = '{BEQ,        3, 0, '{6, 0, 0, 1, 3'd0, 1'b0}};
        vt[7]  = '{HALT_OP,    0, 0, '{2, 0, 0, 0, 3'd5, 1'b0}};
        vt[8]  = '{SW,         0, 5, '{7, 0, 4, 0, 3'd5, 1'b1}};
        vt[9]  = '{6'b010101,  1, 0, '{3, 0, 0, 0, 3'd5, 1'b1}};
        vt[10] = '{ORI,        4, 0, '{4, 0, 0, 0, 3'd5, 1'b1}};

        #12;
        chk("hold_state", 32'(state_o), 0);
        chk("hold_err", 32'(err_o), 0);
        chk("hold_cnt", instr_cnt_o, 0);
        chk("hold_req", 32'(mem_req_o), 0);
        chk("hold_strobes", {ir_we_o, pc_we_o, reg_we_o, mem_we_o, br_en_o}, 0);
        chk("hold_busy", 32'(busy_o), 1);
        rst_n = 1'b1;
        #1 chk("release_req", 32'(mem_req_o), 0);
        @(posedge clk);
        #1;
        chk("fetch_req", 32'(mem_req_o), 1);
        chk("fetch_asb", 32'(alusrc_b_o), 1);
        chk("fetch_iord", 32'(iord_o), 0);

        run_instr(ADDI, 0, 0);
        chk("addi_cycles", n_cyc, 4);
        chk("addi_states", {tr[0].st, tr[1].st, tr[2].st, tr[3].st}, {3'd0, 3'd1, 3'd2, 3'd4});
        chk("addi_fetch_we", {tr[0].irwe, tr[0].pcwe, tr[0].psrc}, 4'b1100);
        chk("addi_reg_we", n_rwe, 1);
        chk("addi_ext", {tr[1].ext, tr[2].ext, tr[3].ext}, 0);
        chk("addi_exec", {tr[2].asb, tr[2].aop}, {2'b10, 3'b000});
        chk("addi_cnt", instr_cnt_o, 1);

        run_instr(ORI, 0, 0);
        chk("ori_exec", {tr[2].ext, tr[2].aop}, {2'b11, 3'b011});
        chk("ori_cnt", instr_cnt_o, 2);

        run_instr(BEQ, 0, 0);
        chk("beq_cycles", n_cyc, 3);
        chk("beq_exec", {tr[2].br, tr[2].psrc, tr[2].ext, tr[2].asa, tr[2].aop}, {1'b1, 2'b01, 2'b01, 1'b1, 3'b001});
        chk("beq_state", 32'(state_o), 0);

        run_instr(LW, 0, 3);
        chk("lw_cycles", n_cyc, 8);
        chk("lw_wb", {tr[7].st, tr[7].m2r, tr[7].rwe, tr[7].rdst}, {3'd4, 3'b110});
        chk("lw_mem_we", n_mwe, 0);
        chk("lw_iord", 32'(tr[3].iord), 1);
        chk("lw_cnt", instr_cnt_o, 4);

        run_instr(6'b111110, 0, 0);
        chk("illegal_cycles", n_cyc, 2);
        chk("illegal_state", 32'(state_o), 5);
        chk("illegal_err", 32'(err_o), 1);
        chk("illegal_cnt", instr_cnt_o, 4);
        do_reset();

        run_instr(ADDI, 9, 0);
        chk("tmo_cycles", n_cyc, 4);
        chk("tmo_state", 32'(state_o), 5);
        chk("tmo_err", 32'(err_o), 1);
        chk("tmo_busy", 32'(busy_o), 0);
        chk("tmo_req", 32'(mem_req_o), 0);
        chk("tmo_ir_we", n_ir, 0);
        do_reset();

        op_i = SW;
        @(negedge clk);
        mem_ack_i = 1'b1;
        @(posedge clk);
        #1 mem_ack_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 chk("sw_mem", {state_o, mem_we_o}, {3'd3, 1'b1});
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("swrst_strobes", {mem_we_o, mem_req_o, pc_we_o, reg_we_o}, 0);
        chk("swrst_state", 32'(state_o), 0);
        chk("swrst_cnt", instr_cnt_o, 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1 chk("swrst_after", {state_o, mem_we_o, pc_we_o}, 0);
        end
        chk("swrst_cnt_after", instr_cnt_o, 0);
        do_reset();

        exp_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            run_instr(vt[i].op, vt[i].fd, vt[i].md);
            check_run($sformatf("vec%0d", i), vt[i].e);
        end

        for (int i = 0; i < 80; i++) begin
            int k, fd, md;
            logic [5:0] op;
            k = int'($urandom_range(0, 9));
            op = k == 9 ? 6'($urandom) : ops[k];
            fd = $urandom_range(0, 7) == 0 ? TO : int'($urandom_range(0, 3));
            md = $urandom_range(0, 7) == 0 ? TO : int'($urandom_range(0, 3));
            run_instr(op, fd, md);
            check_run($sformatf("rnd%0d_op%b", i, op), model(op, fd, md));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, SHALL set the maximum number of cycles mem_req is held without mem_ack before a fault is raised.
REQ-002 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 op  in  6  SHALL carry the opcode field of the instruction register.
REQ-005 funct  in  6  SHALL carry the R-type function field.
REQ-006 mem_ack  in  1  SHALL be the memory completion strobe, valid only while mem_req=1.
REQ-007 mem_req / mem_we / iord  out  1 each  SHALL be the memory request, write enable and address select (0=PC, 1=ALU result).
REQ-008 ir_we / pc_we / br_en / reg_we  out  1 each  SHALL be the IR load, unconditional PC load, branch-if-zero PC load and register-file write strobes.
REQ-009 regdst / memtoreg / alusrc_a  out  1 each  SHALL be the datapath mux selects.
REQ-010 alusrc_b  out  2  SHALL select the ALU B input: 00=reg, 01=const 4, 10=extended immediate.
REQ-011 alu_op  out  3  SHALL carry the ALU operation: 000=add, 001=sub, 010=and, 011=or, 100=R-type decode by funct.
REQ-012 ext_sel  out  2  SHALL select the immediate-extend mode: 11=zero-extend, 01=branch offset, 00=sign-extend.
REQ-013 pc_src  out  2  SHALL select the next PC: 00=ALU, 01=branch target, 10=jump target.
REQ-014 state  out  3  SHALL expose the current state; busy  out  1  SHALL be 1 in every state except HALT; err  out  1  SHALL flag a fault.
REQ-015 instr_cnt  out  32  SHALL count retired instructions.

Function
REQ-016 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6 and 7 SHALL transition to HALT with err=1.
REQ-017 Opcodes SHALL be R=000000, addi=001000, andi=001100, ori=001101, lw=100011, sw=101011, beq=000100, j=000010, halt=111111; any other opcode SHALL be illegal.
REQ-018 FETCH SHALL assert mem_req=1, iord=0, alusrc_a=0, alusrc_b=01, alu_op=000 and stay in FETCH until mem_ack; in the mem_ack cycle it SHALL pulse ir_we=1 and pc_we=1 with pc_src=00, then go to DECODE.
REQ-019 DECODE SHALL last exactly one cycle: j pulses pc_we with pc_src=10, increments instr_cnt and returns to FETCH; halt goes to HALT with err=0; an illegal opcode goes to HALT with err=1; all other opcodes go to EXEC.
REQ-020 ext_sel SHALL be driven from op in DECODE, EXEC, MEM and WB (andi/ori -> 11, beq -> 01, otherwise 00) and SHALL be 00 in FETCH and HALT.
REQ-021 In EXEC, beq SHALL drive alusrc_a=1, alusrc_b=00, alu_op=001, br_en=1 and pc_src=01, increment instr_cnt and return to FETCH.
REQ-022 In EXEC, R-type SHALL use alusrc_b=00 and alu_op=100; addi/andi/ori SHALL use alusrc_b=10 and alu_op 000/010/011 respectively; all of these SHALL go to WB.
REQ-023 In EXEC, lw and sw SHALL use alusrc_b=10 and alu_op=000, then go to MEM.
REQ-024 MEM SHALL hold mem_req=1 and iord=1 (plus mem_we=1 for sw) until mem_ack; on ack, sw SHALL increment instr_cnt and go to FETCH, and lw SHALL go to WB.
REQ-025 WB SHALL pulse reg_we=1 for one cycle, with regdst=1 for R-type and 0 otherwise, memtoreg=1 for lw, then increment instr_cnt and go to FETCH.
REQ-026 Minimum latency SHALL be: j 2 cycles; beq 3; R/addi/andi/ori 4; sw 4; lw 5; each memory wait cycle SHALL add exactly one cycle.
REQ-027 An 8-bit wait counter SHALL clear on entry to FETCH/MEM and increment each cycle mem_req=1 without mem_ack; when it reaches MEM_TIMEOUT the FSM SHALL go to HALT with err=1 and drop mem_req the next cycle.
REQ-028 mem_ack received while mem_req=0 SHALL be ignored.
REQ-029 HALT SHALL drive all strobes to 0, keep err, and remain in HALT until reset.
REQ-030 instr_cnt SHALL wrap from 0xFFFFFFFF to 0.
REQ-031 All outputs other than state, err, instr_cnt and busy SHALL be combinational in state and op, and strobes SHALL never be asserted outside their stated cycles.

Reset
REQ-032 rst_n=0 SHALL immediately force state=FETCH, err=0, instr_cnt=0 and wait counter=0, with all strobes 0 while reset is held; FETCH outputs SHALL resume on the first clock edge after rst_n rises.
REQ-033 Reset asserted mid-instruction, including during a memory wait, SHALL abandon the instruction without a reg_we or pc_we pulse.

Verification
REQ-034 Bench SHALL run addi with mem_ack on the first cycle -> FETCH,DECODE,EXEC,WB over 4 cycles, reg_we once, ext_sel=00, instr_cnt=1.
REQ-035 Bench SHALL run ori -> ext_sel=11, alu_op=011 in EXEC; run beq -> br_en=1, pc_src=01, ext_sel=01, back in FETCH after 3 cycles.
REQ-036 Bench SHALL run lw with mem_ack delayed 3 cycles in MEM -> 8 cycles total, memtoreg=1 in WB, mem_we=0 throughout.
REQ-037 Bench SHALL hold mem_ack=0 in FETCH with MEM_TIMEOUT=4 -> HALT with err=1 after 4 wait cycles, busy=0.
REQ-038 Bench SHALL use opcode 111110 -> HALT with err=1 from DECODE; then pulse rst_n low -> state=0, instr_cnt=0, err=0.
REQ-039 Bench SHALL assert rst_n low during an sw MEM wait -> no mem_we after reset, instr_cnt unchanged at 0.
